traffic_light_ctrl_param: RTL



---
 rtl/traffic_light_ctrl_param_if.sv | 21 ++
 rtl/traffic_light_ctrl_param.sv | 83 ++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_param_if.sv
// traffic_light_ctrl_param_if: tick/request inputs and light/countdown outputs of the traffic controller
interface traffic_light_ctrl_param_if #(parameter int TW = 4);
    logic          tick;
    logic          night_mode;
    logic          ped_req_ns;
    logic          ped_req_ew;
    logic [2:0]    ns_light;
    logic [2:0]    ew_light;
    logic          walk_ns;
    logic          walk_ew;
    logic [TW-1:0] time_left;
    logic [2:0]    state_o;
    modport master (
        output tick, night_mode, ped_req_ns, ped_req_ew,
        input  ns_light, ew_light, walk_ns, walk_ew, time_left, state_o
    );
    modport slave (
        input  tick, night_mode, ped_req_ns, ped_req_ew,
        output ns_light, ew_light, walk_ns, walk_ew, time_left, state_o
    );
endinterface

// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param: NS/EW light sequencer with ped calls, early green end and night flashing
module traffic_light_ctrl_param #(
    parameter int GREEN_T   = 6,
    parameter int MIN_GREEN = 2,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 2,
    parameter int TW        = 4
) (
    input logic clk,
    input logic reset,
    traffic_light_ctrl_param_if.slave bus
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED1   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED2   = 3'd5,
        FLASH     = 3'd6
    } state_t;
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n, last;
    logic          ped_ns, ped_ns_n, ped_ew, ped_ew_n;
    logic          flash, flash_n;
    logic          early, done;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ALLRED2;
            timer  <= '0;
            ped_ns <= 1'b0;
            ped_ew <= 1'b0;
            flash  <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            ped_ns <= ped_ns_n;
            ped_ew <= ped_ew_n;
            flash  <= flash_n;
        end
    end
    // last = DUR-1 of the current phase; FLASH has no countdown
    always_comb begin
        last  = (state == NS_GREEN  || state == EW_GREEN)  ? TW'(GREEN_T - 1)  :
                (state == NS_YELLOW || state == EW_YELLOW) ? TW'(YELLOW_T - 1) :
                (state == FLASH) ? '0 : TW'(ALLRED_T - 1);
        early = bus.tick && timer >= TW'(MIN_GREEN - 1) &&
                ((state == NS_GREEN && ped_ew) || (state == EW_GREEN && ped_ns));
        done  = bus.tick && (timer == last || early);
    end
    always_comb begin
        state_n = state;
        case (state)
            NS_GREEN:  state_n = done ? NS_YELLOW : state;
            NS_YELLOW: state_n = done ? ALLRED1 : state;
            ALLRED1:   state_n = done ? (bus.night_mode ? FLASH : EW_GREEN) : state;
            EW_GREEN:  state_n = done ? EW_YELLOW : state;
            EW_YELLOW: state_n = done ? ALLRED2 : state;
            ALLRED2:   state_n = done ? (bus.night_mode ? FLASH : NS_GREEN) : state;
            FLASH:     state_n = (bus.tick && !bus.night_mode) ? ALLRED2 : state;
            default:   state_n = ALLRED2;
        endcase
        timer_n  = (state_n != state || state == FLASH) ? '0 :
                   bus.tick ? timer + 1'b1 : timer;
        flash_n  = (state != FLASH) ? 1'b0 :
                   bus.tick ? (bus.night_mode & ~flash) : flash;
        // entering a green clears its latch, winning over a same-cycle press
        ped_ns_n = (state_n == NS_GREEN && state != NS_GREEN) ? 1'b0 :
                   ped_ns | (bus.ped_req_ns && state != NS_GREEN);
        ped_ew_n = (state_n == EW_GREEN && state != EW_GREEN) ? 1'b0 :
                   ped_ew | (bus.ped_req_ew && state != EW_GREEN);
    end
    assign bus.ns_light  = state == NS_GREEN  ? 3'b001 :
                           state == NS_YELLOW ? 3'b010 :
                           state == FLASH     ? (flash ? 3'b010 : 3'b000) : 3'b100;
    assign bus.ew_light  = state == EW_GREEN  ? 3'b001 :
                           state == EW_YELLOW ? 3'b010 :
                           state == FLASH     ? (flash ? 3'b100 : 3'b000) : 3'b100;
    assign bus.walk_ns   = state == NS_GREEN;
    assign bus.walk_ew   = state == EW_GREEN;
    assign bus.time_left = last - timer;
    assign bus.state_o   = state;
endmodule
